// File: rtl/qr_sched_pkg.sv
// ---------------------------------------------------------------------------
// qr_sched_pkg: shared constants, FSM states and matrix indexing helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package qr_sched_pkg;

  localparam int ELEM_W = 16;
  localparam int DIM    = 4;
  localparam int MAT_W  = ELEM_W * DIM * DIM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Bit offset of element [i][j] inside a flattened matrix.
  function automatic int elem_idx(input int i, input int j);
    return (i * DIM + j) * ELEM_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/qr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// qr_rr_arbiter: combinational round-robin pick, first request at/after pointer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qr_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_grant
);

  always_comb begin
    int k;
    logic [ID_W-1:0] idx;
    k         = 0;
    idx       = '0;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // Pointer is always < NUM_REQ, so a single wrap subtraction suffices.
    for (int off = 0; off < NUM_REQ; off++) begin
      k = int'(pointer) + off;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      idx = ID_W'(k);
      if (!any_grant && req[idx]) begin
        any_grant  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/qr_job_scheduler.sv
// ---------------------------------------------------------------------------
// qr_job_scheduler: shares one QR core among NUM_REQ requesters, with timeout.
// Optional statistics outputs enabled by defining QR_SCHED_STATS_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module qr_job_scheduler
  import qr_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int MAT_W          = qr_sched_pkg::MAT_W
) (
  input  logic                     clk_100mhz,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*MAT_W-1:0] req_matrix,
  output logic [MAT_W-1:0]         core_matrix,
  output logic                     core_start,
  output logic                     core_abort,
  input  logic                     core_done,
  input  logic [MAT_W-1:0]         core_r,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [MAT_W-1:0]         rsp_r,
  output logic                     rsp_err
`ifdef QR_SCHED_STATS_EN
  ,
  output logic [31:0]              stat_jobs,
  output logic [15:0]              stat_timeouts,
  output logic [15:0]              stat_max_lat
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     rr_ptr;
  logic [CNT_W-1:0]    count;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_idx;
  logic                any_grant;
  logic                timeout_hit;

  qr_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (req_valid),
    .pointer   (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign timeout_hit = (count == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      count       <= '0;
      core_matrix <= '0;
      rsp_id      <= '0;
      rsp_r       <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_grant) begin
          core_matrix <= req_matrix[grant_idx*MAT_W +: MAT_W];
          rsp_id      <= grant_idx;
          rr_ptr      <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
        START: count <= '0;
        WAIT: begin
          count <= count + 1'b1;
          // A done arriving on the timeout cycle still counts as success.
          if (core_done) begin
            rsp_r   <= core_r;
            rsp_err <= 1'b0;
          end else if (timeout_hit) begin
            rsp_r   <= '0;
            rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    core_start = 1'b0;
    core_abort = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: if (any_grant) begin
        req_ready = grant;
        state_nxt = START;
      end
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          state_nxt = RESP;
        end else if (timeout_hit) begin
          core_abort = 1'b1;
          state_nxt  = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef QR_SCHED_STATS_EN
  logic [31:0] lat_now;
  logic [15:0] lat_sat;

  // Cycles from START to the done cycle: START itself plus count WAIT cycles.
  assign lat_now = 32'(count) + 32'd1;
  assign lat_sat = (lat_now > 32'h0000_FFFF) ? 16'hFFFF : lat_now[15:0];

  always_ff @(posedge clk_100mhz or posedge reset) begin
    if (reset) begin
      stat_jobs     <= '0;
      stat_timeouts <= '0;
      stat_max_lat  <= '0;
    end else if (state == WAIT) begin
      if (core_done) begin
        stat_jobs <= stat_jobs + 32'd1;
        if (lat_sat > stat_max_lat) stat_max_lat <= lat_sat;
      end else if (timeout_hit) begin
        stat_timeouts <= stat_timeouts + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_qr_job_scheduler.sv
// ---------------------------------------------------------------------------
// tb_qr_job_scheduler: scoreboard bench for qr_job_scheduler with a core model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_qr_job_scheduler;
  import qr_sched_pkg::*;

  localparam int NR  = 4;
  localparam int IDW = 2;
  localparam int TMO = 32;

  typedef struct packed {
    logic [IDW-1:0]   id;
    logic [MAT_W-1:0] r;
    logic             err;
  } exp_t;

  logic                clk_100mhz = 1'b0;
  logic                reset = 1'b1;
  logic [NR-1:0]       req_valid = '0;
  logic [NR-1:0]       req_ready;
  logic [NR*MAT_W-1:0] req_matrix;
  logic [MAT_W-1:0]    core_matrix;
  logic                core_start, core_abort;
  logic                core_done = 1'b0;
  logic [MAT_W-1:0]    core_r = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [IDW-1:0]      rsp_id;
  logic [MAT_W-1:0]    rsp_r;
  logic                rsp_err;

  logic [MAT_W-1:0] mats [NR];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   core_lat = 0;
  bit   armed = 1'b0;
  int   done_at = 0;

  for (genvar gi = 0; gi < NR; gi++) begin : g_mat
    assign req_matrix[gi*MAT_W +: MAT_W] = mats[gi];
  end

  qr_job_scheduler #(
    .NUM_REQ(NR), .ID_W(IDW), .TIMEOUT_CYCLES(TMO), .MAT_W(MAT_W)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_matrix (req_matrix),
    .core_matrix(core_matrix),
    .core_start (core_start),
    .core_abort (core_abort),
    .core_done  (core_done),
    .core_r     (core_r),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_r      (rsp_r),
    .rsp_err    (rsp_err)
  );

  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // Stand-in core result: a fixed permutation/XOR of the input matrix.
  function automatic logic [MAT_W-1:0] r_model(input logic [MAT_W-1:0] m);
    return {m[MAT_W/2-1:0], m[MAT_W-1:MAT_W/2]} ^ {16{16'h1357}};
  endfunction

  function automatic exp_t got_rsp();
    return exp_t'({rsp_id, rsp_r, rsp_err});
  endfunction

  // Core model: core_lat = cycles from grant to done; 0 means never done.
  initial begin
    forever begin
      @(posedge clk_100mhz); #1;
      core_done = 1'b0;
      if (reset) begin
        armed = 1'b0;
      end else begin
        if (armed && cyc == done_at) begin
          core_done = 1'b1;
          armed     = 1'b0;
        end
        if (core_start && core_lat > 1) begin
          armed   = 1'b1;
          done_at = cyc + core_lat - 1;
          core_r  = r_model(core_matrix);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_100mhz); #3;
  endtask

  // Returns the number of ticks until rsp_valid, or -1 when the budget expires.
  task automatic wait_rsp(input int budget, output int waited);
    waited = -1;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (rsp_valid) begin
        waited = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rsp_ready = 1'b0; req_valid = '0; core_lat = 0;
    repeat (3) tick();
    checks++;
    if ({req_ready, core_start, core_abort, rsp_valid, rsp_err} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {req_ready, core_start, core_abort, rsp_valid, rsp_err});
    end
    checks++;
    if (rsp_id !== '0) begin errors++; $display("FAIL reset_id: got %0d want 0", rsp_id); end
    checks++;
    if (rsp_r !== '0) begin errors++; $display("FAIL reset_r: got %h want 0", rsp_r); end
    checks++;
    if (core_matrix !== '0) begin errors++; $display("FAIL reset_cmat: got %h want 0", core_matrix); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int grants = 0, rsps = 0;
    logic [NR-1:0] prev = '0;
    exp_t e;
    req_valid = '1; rsp_ready = 1'b1; core_lat = 3;
    for (int n = 0; n < 400 && rsps < 8; n++) begin
      #1;
      if (rsp_valid) begin
        rsps++; checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL fair_rsp: unexpected response id %0d", rsp_id); end
        else begin
          e = exp_q.pop_front();
          if (got_rsp() !== e) begin errors++; $display("FAIL fair_rsp: got %h want %h", got_rsp(), e); end
        end
      end
      if (req_ready != '0 && grants < 8) begin
        checks++;
        if (req_ready !== NR'(1 << (grants % NR))) begin
          errors++; $display("FAIL fair_order: job %0d got %b want %b", grants, req_ready, NR'(1 << (grants % NR)));
        end
        checks++;
        if (req_ready === prev) begin errors++; $display("FAIL fair_repeat: got %b twice, want a different requester", req_ready); end
        prev = req_ready;
        exp_q.push_back(exp_t'({IDW'(grants % NR), r_model(mats[grants % NR]), 1'b0}));
        grants++;
      end
      tick();
      if (grants >= 8) req_valid = '0;
    end
    checks++;
    if (rsps != 8) begin errors++; $display("FAIL fair_count: got %0d responses want 8", rsps); exp_q.delete(); end
  endtask

  task automatic test_single();
    int w;
    exp_t e;
    mats[1] = '0;
    for (int d = 0; d < DIM; d++) mats[1][elem_idx(d, d) +: ELEM_W] = 16'h2000;
    core_lat = 20; rsp_ready = 1'b1; req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", req_ready); end
    exp_q.push_back(exp_t'({IDW'(1), r_model(mats[1]), 1'b0}));
    tick(); req_valid = '0;
    checks++;
    if (core_start !== 1'b1) begin errors++; $display("FAIL single_start: got %b want 1", core_start); end
    checks++;
    if (core_matrix !== mats[1]) begin errors++; $display("FAIL single_cmat: got %h want %h", core_matrix, mats[1]); end
    wait_rsp(100, w);
    checks++;
    if (w + 1 != 21) begin errors++; $display("FAIL single_lat: rsp_valid at cycle %0d want 21", w + 1); end
    checks++;
    if (w < 0) exp_q.delete();
    else begin
      e = exp_q.pop_front();
      if (got_rsp() !== e) begin errors++; $display("FAIL single_rsp: got %h want %h", got_rsp(), e); end
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drop: rsp_valid %b want 0", rsp_valid); end
  endtask

  // Runs one job on requester gid and tracks core_abort / rsp_valid timing.
  task automatic test_long_job(input string tag, input int gid, input int lat,
                               input bit want_err, input int want_aborts);
    int abort_cnt = 0, abort_at = -1, rsp_at = -1;
    exp_t e;
    core_lat = lat; rsp_ready = 1'b1; req_valid = NR'(1 << gid);
    #1;
    checks++;
    if (req_ready !== NR'(1 << gid)) begin errors++; $display("FAIL %s_grant: got %b want %b", tag, req_ready, NR'(1 << gid)); end
    exp_q.push_back(exp_t'({IDW'(gid), want_err ? {MAT_W{1'b0}} : r_model(mats[gid]), want_err}));
    tick(); req_valid = '0;
    for (int c = 2; c <= TMO + 10; c++) begin
      tick();
      if (core_abort) begin abort_cnt++; abort_at = c; end
      if (rsp_valid && rsp_at < 0) begin
        rsp_at = c; checks++;
        e = exp_q.pop_front();
        if (got_rsp() !== e) begin errors++; $display("FAIL %s_rsp: got %h want %h", tag, got_rsp(), e); end
      end
    end
    checks++;
    if (abort_cnt != want_aborts) begin errors++; $display("FAIL %s_aborts: got %0d want %0d", tag, abort_cnt, want_aborts); end
    if (want_aborts == 1) begin
      checks++;
      if (abort_at != TMO + 1) begin errors++; $display("FAIL %s_abort_at: got %0d want %0d", tag, abort_at, TMO + 1); end
    end
    checks++;
    if (rsp_at != TMO + 2) begin errors++; $display("FAIL %s_rsp_at: got %0d want %0d", tag, rsp_at, TMO + 2); exp_q.delete(); end
  endtask

  task automatic test_timeout();
    int w;
    exp_t e;
    test_long_job("timeout", 2, 0, 1'b1, 1);
    core_lat = 5; req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL after_to_grant: got %b want 1000", req_ready); end
    exp_q.push_back(exp_t'({IDW'(3), r_model(mats[3]), 1'b0}));
    tick(); req_valid = '0;
    wait_rsp(50, w);
    checks++;
    if (w != 5) begin errors++; $display("FAIL after_to_lat: got %0d want 5", w); exp_q.delete(); end
    else begin
      e = exp_q.pop_front();
      if (got_rsp() !== e) begin errors++; $display("FAIL after_to_rsp: got %h want %h", got_rsp(), e); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int w;
    bit stable = 1'b1;
    exp_t e, snap;
    core_lat = 4; rsp_ready = 1'b0; req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    exp_q.push_back(exp_t'({IDW'(1), r_model(mats[1]), 1'b0}));
    tick(); req_valid = 4'b1000;
    wait_rsp(50, w);
    snap = got_rsp();
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rsp_valid !== 1'b1 || got_rsp() !== snap || req_ready !== '0) stable = 1'b0;
    end
    checks++;
    if (!stable || w < 0) begin errors++; $display("FAIL bp_stable: stable=%0d wait=%0d want stable=1", stable, w); end
    rsp_ready = 1'b1;
    checks++;
    e = exp_q.pop_front();
    if (got_rsp() !== e) begin errors++; $display("FAIL bp_rsp: got %h want %h", got_rsp(), e); end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_single: rsp_valid %b want 0", rsp_valid); end
    checks++;
    if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_regrant: got %b want 1000", req_ready); end
    exp_q.push_back(exp_t'({IDW'(3), r_model(mats[3]), 1'b0}));
    tick(); req_valid = '0;
    wait_rsp(50, w);
    checks++;
    if (w < 0) begin errors++; $display("FAIL bp_next: no response want one"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front();
      if (got_rsp() !== e) begin errors++; $display("FAIL bp_next: got %h want %h", got_rsp(), e); end
    end
    tick();
  endtask

  task automatic test_async_reset();
    int w;
    exp_t e;
    core_lat = 0; rsp_ready = 1'b1; req_valid = 4'b0100;
    tick(); req_valid = '0;
    repeat (5) tick();
    #3; reset = 1'b1; #1;
    checks++;
    if ({req_ready, core_start, core_abort, rsp_valid, rsp_err} !== '0 || rsp_id !== '0 ||
        rsp_r !== '0 || core_matrix !== '0) begin
      errors++; $display("FAIL async_rst: ctrl=%b id=%0d cmat_nz=%0d want all 0",
        {req_ready, core_start, core_abort, rsp_valid, rsp_err}, rsp_id, core_matrix != '0);
    end
    req_valid = '1;
    repeat (2) tick();
    reset = 1'b0; #1;
    checks++;
    if (req_ready !== 4'b0001) begin errors++; $display("FAIL async_ptr: got %b want 0001", req_ready); end
    core_lat = 4;
    exp_q.push_back(exp_t'({IDW'(0), r_model(mats[0]), 1'b0}));
    tick(); req_valid = '0;
    wait_rsp(50, w);
    checks++;
    if (w < 0) begin errors++; $display("FAIL async_job: no response want one"); exp_q.delete(); end
    else begin
      e = exp_q.pop_front();
      if (got_rsp() !== e) begin errors++; $display("FAIL async_job: got %h want %h", got_rsp(), e); end
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < DIM * DIM; k++) mats[i][k*ELEM_W +: ELEM_W] = 16'($urandom);
    test_reset();
    test_fairness();
    test_single();
    test_timeout();
    test_long_job("collision", 0, TMO + 1, 1'b0, 0);
    test_backpressure();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover: %0d expected responses never seen, want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
